// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel/accumulator types, pooling FSM states and 2x2 averaging arithmetic.
//   Build option AVG_POOL_ROUND_EN: defined -> round-half-up average of the exact 18-bit sum;
//   undefined -> sum of per-pixel quarters (bit-exact with the software model).
package cnn_pkg;
    typedef logic [15:0] pixel_t;
    typedef logic [17:0] acc_t;
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} avg_pool_state_e;
    // What one pixel adds to the window accumulator.
    function automatic acc_t pool_term(pixel_t p);
`ifdef AVG_POOL_ROUND_EN
        return acc_t'(p);
`else
        return acc_t'(p >> 2);
`endif
    endfunction
    // Final average from the accumulated terms of one 2x2 window.
    function automatic pixel_t pool_avg(acc_t acc);
`ifdef AVG_POOL_ROUND_EN
        return pixel_t'((acc + acc_t'(2)) >> 2);
`else
        return pixel_t'(acc);
`endif
    endfunction
endpackage

// File: rtl/avg_pool_addr_gen.sv
// avg_pool_addr_gen: window/phase counters and source/destination address offsets for avg_pool_seq.
//   clk_i, reset_i   clock, synchronous active-high reset
//   phase_inc_i      advance read phase (0..3, wraps)
//   win_inc_i        advance window: c fastest, then r, then ch; wraps to 0 after the last
//   phase_o          phase of the next read to issue
//   last_o           current window is the last of the job
//   rd_off_o         source offset of the current (window, phase), mod 2^AW
//   wr_off_o         destination offset of the current window, mod 2^AW
module avg_pool_addr_gen import cnn_pkg::*; #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int N_CH  = 1,
    parameter int AW    = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          phase_inc_i,
    input  logic          win_inc_i,
    output logic [1:0]    phase_o,
    output logic          last_o,
    output logic [AW-1:0] rd_off_o,
    output logic [AW-1:0] wr_off_o
);
    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam logic [AW-1:0] W_A    = AW'(IMG_W);
    localparam logic [AW-1:0] PLANE  = AW'(IMG_W * IMG_H);
    localparam logic [AW-1:0] OW_A   = AW'(OW);
    localparam logic [AW-1:0] OPLANE = AW'(OW * OH);
    localparam logic [AW-1:0] C_MAX  = AW'(OW - 1);
    localparam logic [AW-1:0] R_MAX  = AW'(OH - 1);
    localparam logic [AW-1:0] CH_MAX = AW'(N_CH - 1);
    logic [1:0]    ph_q;
    logic [AW-1:0] c_q, r_q, ch_q;
    logic          c_last, r_last, ch_last;
    assign c_last  = c_q == C_MAX;
    assign r_last  = r_q == R_MAX;
    assign ch_last = ch_q == CH_MAX;
    assign last_o  = c_last && r_last && ch_last;
    assign phase_o = ph_q;
    // Phase bit 1 selects the lower row of the window, bit 0 the right column.
    assign rd_off_o = ch_q * PLANE + {r_q[AW-2:0], ph_q[1]} * W_A + {c_q[AW-2:0], ph_q[0]};
    assign wr_off_o = ch_q * OPLANE + r_q * OW_A + c_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ph_q <= '0;
            c_q  <= '0;
            r_q  <= '0;
            ch_q <= '0;
        end else begin
            if (phase_inc_i)
                ph_q <= ph_q + 2'd1;
            if (win_inc_i) begin
                c_q  <= c_last ? '0 : c_q + AW'(1);
                r_q  <= !c_last ? r_q : r_last ? '0 : r_q + AW'(1);
                ch_q <= !(c_last && r_last) ? ch_q : ch_last ? '0 : ch_q + AW'(1);
            end
        end
    end
endmodule

// File: rtl/avg_pool_seq.sv
// avg_pool_seq: sequencer that 2x2/stride-2 average-pools feature maps from a single-port RAM.
//   Build option AVG_POOL_ROUND_EN selects round-half-up averaging (see cnn_pkg).
//   clk_i, reset_i      clock, synchronous active-high reset (aborts a job, no done)
//   start_i             begin a job, sampled only when idle
//   src_base_i          word address of channel 0 pixel (0,0), latched on start
//   dst_base_i          word address of the first output, latched on start
//   busy_o              high from the cycle after start through the done cycle
//   done_o              one-cycle pulse after the last write is accepted
//   rd_en_o, rd_addr_o  source read strobe and address; rd_data_i returns one cycle later
//   wr_en_o, wr_addr_o, wr_data_o  destination write, held until wr_ready_i
module avg_pool_seq import cnn_pkg::*; #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int N_CH  = 1,
    parameter int AW    = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [AW-1:0] src_base_i,
    input  logic [AW-1:0] dst_base_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  pixel_t        rd_data_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output pixel_t        wr_data_o,
    input  logic          wr_ready_i
);
    if (IMG_W < 2 || IMG_W % 2 != 0 || IMG_H < 2 || IMG_H % 2 != 0) begin : g_bad_dims
        $error("avg_pool_seq: IMG_W and IMG_H must be even and >= 2");
    end
    avg_pool_state_e state_q;
    logic            busy_q, done_q, rd_en_q, wr_en_q, last_q;
    logic [AW-1:0]   rd_addr_q, wr_addr_q, src_q, dst_q;
    pixel_t          wr_data_q;
    acc_t            acc_q, acc_d;
    logic [1:0]      phase;
    logic            last, phase_inc, win_inc;
    logic [AW-1:0]   rd_off, wr_off;
    // The address generator's phase is the next read to issue; 0 while in RD means the
    // window's fourth read is already on the bus.
    assign phase_inc = (state_q == IDLE && start_i) || (state_q == RD && phase != 2'd0) ||
                       (state_q == WR && wr_ready_i && !last_q);
    // Window counters step as the write is prepared, so WR already sees the next window.
    assign win_inc = state_q == WAIT;
    assign acc_d   = acc_q + pool_term(rd_data_i);
    avg_pool_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .N_CH(N_CH), .AW(AW)) u_addr (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .phase_inc_i (phase_inc),
        .win_inc_i   (win_inc),
        .phase_o     (phase),
        .last_o      (last),
        .rd_off_o    (rd_off),
        .wr_off_o    (wr_off)
    );
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            last_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            acc_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q   <= RD;
                    busy_q    <= 1'b1;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= src_base_i + rd_off;
                    src_q     <= src_base_i;
                    dst_q     <= dst_base_i;
                    acc_q     <= '0;
                end
                RD: begin
                    // Data returns one cycle late: skip the cycle that issues read 0.
                    if (phase != 2'd1)
                        acc_q <= acc_d;
                    if (phase == 2'd0) begin
                        state_q <= WAIT;
                        rd_en_q <= 1'b0;
                    end else
                        rd_addr_q <= src_q + rd_off;
                end
                WAIT: begin
                    state_q   <= WR;
                    acc_q     <= acc_d;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= dst_q + wr_off;
                    wr_data_q <= pool_avg(acc_d);
                    last_q    <= last;
                end
                WR: if (wr_ready_i) begin
                    wr_en_q <= 1'b0;
                    if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= RD;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= src_q + rd_off;
                        acc_q     <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
endmodule

// File: tb/tb_avg_pool_seq.sv
// tb_avg_pool_seq: scoreboard bench for avg_pool_seq on 4x4 maps, 2 channels.
module tb_avg_pool_seq;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NC   = 2;
    localparam int NWIN = (W / 2) * (H / 2) * NC;
`ifdef AVG_POOL_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, wr_ready = 1'b1;
    logic [15:0] src_base = '0, dst_base = '0, rd_data = '0;
    logic        busy, done, rd_en, wr_en;
    logic [15:0] rd_addr, wr_addr, wr_data;
    logic [15:0] mem [0:65535];
    logic [15:0] exp_rd [$];
    logic [31:0] exp_wr [$];
    logic [15:0] rd_log [64];
    logic [15:0] wr_log [64];
    logic [15:0] wr_alog [64];
    logic [15:0] e4 [4] = '{16'h0100, 16'h0101, 16'h0104, 16'h0105};
    int          n_chk = 0, n_pass = 0;
    int          rd_cnt = 0, wr_cnt = 0, stall_idx = -1, stall_left = 0;
    logic        hold_chk = 1'b0;
    logic [31:0] held = '0;

    avg_pool_seq #(.IMG_W(W), .IMG_H(H), .N_CH(NC), .AW(16)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .src_base_i (src_base),
        .dst_base_i (dst_base),
        .busy_o     (busy),
        .done_o     (done),
        .rd_en_o    (rd_en),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .wr_en_o    (wr_en),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .wr_ready_i (wr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (hold_chk) begin
            chk("wr_hold_en", 32'(wr_en), 1);
            chk("wr_hold", {wr_addr, wr_data}, held);
        end
        wr_ready = !(wr_en && wr_cnt == stall_idx && stall_left > 0);
        if (!wr_ready)
            stall_left--;
        hold_chk = wr_en && !wr_ready;
        held = {wr_addr, wr_data};
        if (rd_en) begin
            chk("rd_wr_excl", 32'(wr_en), 0);
            chk("rd_pending", 32'(exp_rd.size() > 0), 1);
            if (exp_rd.size() > 0)
                chk("rd_addr", 32'(rd_addr), 32'(exp_rd.pop_front()));
            if (rd_cnt < 64)
                rd_log[rd_cnt] = rd_addr;
            rd_cnt++;
        end
        if (wr_en && wr_ready) begin
            chk("wr_pending", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0)
                chk("wr", {wr_addr, wr_data}, exp_wr.pop_front());
            if (wr_cnt < 64) begin
                wr_log[wr_cnt] = wr_data;
                wr_alog[wr_cnt] = wr_addr;
            end
            wr_cnt++;
        end
    end

    task automatic push_job(input logic [15:0] src, input logic [15:0] dst);
        int sum, sumq, v;
        logic [15:0] a;
        for (int ch = 0; ch < NC; ch++)
            for (int r = 0; r < H / 2; r++)
                for (int c = 0; c < W / 2; c++) begin
                    sum = 0;
                    sumq = 0;
                    for (int p = 0; p < 4; p++) begin
                        a = src + 16'(ch * W * H + (2 * r + p / 2) * W + 2 * c + p % 2);
                        exp_rd.push_back(a);
                        sum += int'(mem[a]);
                        sumq += int'(mem[a]) / 4;
                    end
                    v = RND ? (sum + 2) / 4 : sumq;
                    exp_wr.push_back({dst + 16'(ch * (W / 2) * (H / 2) + r * (W / 2) + c), 16'(v)});
                end
    endtask

    task automatic run_job(input logic [15:0] src, input logic [15:0] dst, input int s_idx, input int s_len);
        int lat, nb;
        bit got;
        lat = 6 * NWIN + 1 + s_len;
        nb = 0;
        got = 1'b0;
        src_base = src;
        dst_base = dst;
        stall_idx = s_idx;
        stall_left = s_len;
        rd_cnt = 0;
        wr_cnt = 0;
        push_job(src, dst);
        start = 1'b1;
        for (int n = 1; n <= lat + 20 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                chk("busy_rise", 32'(busy), 1);
            end
            if (n == 10) begin
                start = 1'b1;
                src_base = 16'h0bad;
                dst_base = 16'h0bad;
            end
            if (n == 11)
                start = 1'b0;
            nb += int'(busy);
            if (done) begin
                got = 1'b1;
                start = 1'b1;
                chk("latency", n, lat);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_seen", 32'(got), 1);
        chk("busy_cycles", nb, lat);
        chk("after_done", {busy, done, rd_en}, 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
    endtask

    initial begin
        logic quiet;
        for (int i = 0; i < 65536; i++)
            mem[i] = 16'(i * 40503 + 12345) ^ 16'(i >> 3);
        mem[16'h0100] = 16'd4;
        mem[16'h0101] = 16'd8;
        mem[16'h0104] = 16'd12;
        mem[16'h0105] = 16'd16;
        mem[16'h0200] = 16'd1;
        mem[16'h0201] = 16'd1;
        mem[16'h0204] = 16'd1;
        mem[16'h0205] = 16'd2;
        mem[16'h0202] = 16'hffff;
        mem[16'h0203] = 16'hffff;
        mem[16'h0206] = 16'hffff;
        mem[16'h0207] = 16'hffff;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {busy, done, rd_en, wr_en}, 0);
        chk("rst_addr", {rd_addr, wr_addr}, 0);
        chk("rst_data", 32'(wr_data), 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ctl", {busy, done, rd_en, wr_en}, 0);
        end
        run_job(16'h0100, 16'h0800, -1, 0);
        for (int i = 0; i < 4; i++)
            chk("t2_rd_addr", 32'(rd_log[i]), 32'(e4[i]));
        chk("t2_wr_addr", 32'(wr_alog[0]), 32'h0800);
        chk("t2_wr_data", 32'(wr_log[0]), 10);
        chk("t2_writes", wr_cnt, NWIN);
        run_job(16'h0200, 16'h0900, 1, 7);
        chk("t3_small", 32'(wr_log[0]), RND ? 1 : 0);
        chk("t3_max", 32'(wr_log[1]), RND ? 32'hffff : 32'hfffc);
        run_job(16'hfff0, 16'hfffe, -1, 0);
        chk("t5_rd_wrap", 32'(rd_log[16]), 32'h0000);
        chk("t5_wr_wrap", 32'(wr_alog[NWIN - 1]), 32'h0005);
        run_job(16'($urandom), 16'($urandom), 5, 3);
        src_base = 16'h0300;
        dst_base = 16'h0a00;
        push_job(16'h0300, 16'h0a00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("t6_mid_rd", 32'(rd_en), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_ctl", {busy, done, rd_en, wr_en}, 0);
        chk("t6_rd_addr", 32'(rd_addr), 0);
        chk("t6_wr", {wr_addr, wr_data}, 0);
        exp_rd.delete();
        exp_wr.delete();
        quiet = 1'b0;
        repeat (12) begin
            @(negedge clk);
            quiet |= busy | done | rd_en | wr_en;
        end
        chk("t6_quiet", 32'(quiet), 0);
        run_job(16'h0400, 16'h0c00, 2, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
